// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline definitions: machine width, the canonical NOP and the
// IF/ID bundle handed from fetch to decode.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } if_id_t;

    // Empty IF/ID slot; pc_plus4 stays consistent with pc so decode never sees a mismatch.
    localparam if_id_t IF_ID_RESET = '{
        valid:    1'b0,
        pc:       '0,
        pc_plus4: INSTR_BYTES,
        instr:    NOP_INSTR
    };

    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with reset > flush > hold > load priority.
module if_id_reg
    import rv32_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    // A flush only kills the instruction; pc fields are left alone so decode
    // still sees a stable (if meaningless) address during the bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= IF_ID_RESET;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle-latency instruction memory
// and feeds the IF/ID register.
module if_stage
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [XLEN-1:0] id_instr
);

    logic [XLEN-1:0] pc_q;
    logic            fv_q;
    logic [XLEN-1:0] npc;
    logic            unused_redirect_lsbs;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    // Misaligned targets are silently aligned, so the low bits are dropped.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Next fetch address; on a stall the same word is re-read so it reappears next cycle.
    always_comb begin
        npc = seq_pc(pc_q);
        if (reset) begin
            npc = RESET_PC;
        end else if (redirect_valid) begin
            npc = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (stall_f) begin
            npc = pc_q;
        end
    end

    assign imem_en   = 1'b1;
    assign imem_addr = npc;

    always_ff @(posedge clk) begin
        pc_q <= npc;
        if (reset || redirect_valid) begin
            fv_q <= 1'b1;
        end
    end

    always_comb begin
        if_id_d.valid    = fv_q;
        if_id_d.pc       = pc_q;
        if_id_d.pc_plus4 = seq_pc(pc_q);
        if_id_d.instr    = fv_q ? imem_rdata : NOP_INSTR;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .hold  (stall_f),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign id_valid    = if_id_q.valid;
    assign id_pc       = if_id_q.pc;
    assign id_pc_plus4 = if_id_q.pc_plus4;
    assign id_instr    = if_id_q.instr;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// stall/redirect/reset traffic, compared against a cycle-level reference.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;

    int errors;
    int checks;

    // Reference state: the word address whose data is currently arriving,
    // and the expected content of the decode slot.
    logic [31:0] mArriving;
    logic        mCorrectPath;
    logic        mValid;
    logic [31:0] mPc;
    logic [31:0] mPc4;
    logic [31:0] mInstr;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_f        (stall_f),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    // Synchronous instruction memory: registers the address at the edge.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= memWord(imem_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stl, input logic rdv, input logic [31:0] rpc);
        logic [31:0] target;
        reset          = rst;
        stall_f        = stl;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        if (rst)      target = RST_PC;
        else if (rdv) target = rpc & 32'hFFFF_FFFC;
        else if (stl) target = mArriving;
        else          target = mArriving + 32'd4;
        #1;
        checkOutput("imem_addr", imem_addr, target);
        checkOutput("imem_en", {31'd0, imem_en}, 32'd1);
        @(posedge clk);
        if (rst) begin
            mValid = 1'b0; mInstr = NOP; mPc = 32'd0; mPc4 = 32'd4;
        end else if (rdv) begin
            mValid = 1'b0; mInstr = NOP;
        end else if (!stl) begin
            mValid = mCorrectPath;
            mInstr = mCorrectPath ? memWord(mArriving) : NOP;
            mPc    = mArriving;
            mPc4   = mArriving + 32'd4;
        end
        if (rst || rdv) mCorrectPath = 1'b1;
        mArriving = target;
        #1;
        checkOutput("id_valid", {31'd0, id_valid}, {31'd0, mValid});
        checkOutput("id_pc", id_pc, mPc);
        checkOutput("id_pc_plus4", id_pc_plus4, mPc4);
        checkOutput("id_instr", id_instr, mInstr);
    endtask

    task automatic runFree(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mArriving = RST_PC; mCorrectPath = 1'b1;
        mValid = 1'b0; mPc = 32'd0; mPc4 = 32'd4; mInstr = NOP;
        reset = 1'b1; stall_f = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        $display("[TB] reset and free run");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        runFree(4);

        $display("[TB] three-cycle stall");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        runFree(6);

        $display("[TB] redirect to 0x100");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        runFree(4);

        $display("[TB] redirect with stall to 0x203");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0203);
        runFree(3);

        $display("[TB] reset with redirect and stall");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        runFree(3);

        $display("[TB] wrap past top of address space");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        runFree(4);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            logic rst, stl, rdv;
            rst = ($urandom_range(0, 39) == 0);
            stl = ($urandom_range(0, 3) == 0);
            rdv = ($urandom_range(0, 7) == 0);
            applyStimulus(rst, stl, rdv, $urandom);
        end
        runFree(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
